mul_accumulator: RTL and testbench

MUL_ACCUMULATOR -- requirements
Module: mul_accumulator

---
 rtl/mul_accumulator.sv | 144 ++++++++++++++
 tb/tb_mul_accumulator.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_accumulator.sv
// ---------------------------------------------------------------------------
// mul_accumulator
// Sums a burst of signed 16-bit products into a signed ACC_W-bit accumulator
// and presents the result with a valid/ready handshake.
//
// Optional feature macro: MUL_ACCUMULATOR_SAT_EN
//   defined   -> an overflowing add clamps to the signed max/min of ACC_W
//   undefined -> an overflowing add wraps modulo 2^ACC_W
//   In both builds, ovf is set on overflow and stays set until the next
//   accepted start or reset.
//
// Ports
//   clk         in   1      clock; all state updates on the rising edge
//   rst         in   1      synchronous, active-high reset
//   start       in   1      begin a burst (honoured only in IDLE)
//   len         in   8      burst length, sampled with start; 0 means 256
//   prod        in   16     signed product from the multiplier
//   prod_valid  in   1      prod is valid this cycle
//   prod_ready  out  1      block accepts prod this cycle (ACC state)
//   acc         out  ACC_W  signed accumulated result
//   acc_valid   out  1      acc holds a completed burst sum (HOLD state)
//   acc_ready   in   1      consumer takes acc this cycle
//   busy        out  1      high in any state other than IDLE
//   ovf         out  1      sticky signed-overflow flag for the current burst
// ---------------------------------------------------------------------------
module mul_accumulator #(
  parameter int unsigned ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              len,
  input  logic [15:0]             prod,
  input  logic                    prod_valid,
  output logic                    prod_ready,
  output logic signed [ACC_W-1:0] acc,
  output logic                    acc_valid,
  input  logic                    acc_ready,
  output logic                    busy,
  output logic                    ovf
);

  localparam int unsigned CNT_W = 9;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_rem;
  logic                    r_ovf;
  logic                    r_prod_ready;
  logic                    r_acc_valid;
  logic                    r_busy;

  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_acc_next;
  logic                    w_ovf_add;

  // Sign-extend the product and form the raw sum
  assign w_prod_ext = ACC_W'(signed'(prod));
  assign w_sum      = r_acc + w_prod_ext;

  // Overflow: operands share a sign and the result sign differs from it
  assign w_ovf_add  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                      (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef MUL_ACCUMULATOR_SAT_EN
  // Clamp toward the common operand sign on overflow
  assign w_acc_next = w_ovf_add ? (r_acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : w_sum;
`else
  // Wrap modulo 2^ACC_W; the unused clamp limits are tied off here
  logic w_unused_lim;
  assign w_unused_lim = ^{ACC_MAX, ACC_MIN};
  assign w_acc_next   = w_sum;
`endif

  // Burst FSM with registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_rem        <= '0;
      r_ovf        <= 1'b0;
      r_prod_ready <= 1'b0;
      r_acc_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // len of 0 encodes a full 256-product burst
            r_rem        <= (len == 8'd0) ? CNT_W'(256) : CNT_W'(len);
            r_acc        <= '0;
            r_ovf        <= 1'b0;
            r_state      <= S_ACC;
            r_prod_ready <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_ACC: begin
          if (prod_valid) begin
            r_acc <= w_acc_next;
            r_rem <= r_rem - CNT_W'(1);
            if (w_ovf_add) begin
              r_ovf <= 1'b1;
            end
            if (r_rem == CNT_W'(1)) begin
              r_state      <= S_HOLD;
              r_prod_ready <= 1'b0;
              r_acc_valid  <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (acc_ready) begin
            r_state     <= S_IDLE;
            r_acc_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_prod_ready <= 1'b0;
          r_acc_valid  <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign prod_ready = r_prod_ready;
  assign acc        = r_acc;
  assign acc_valid  = r_acc_valid;
  assign busy       = r_busy;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_mul_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mul_accumulator
// Directed, self-checking bench. Two instances share all inputs: u_dut24
// (ACC_W=24, default) and u_dut16 (ACC_W=16, used for overflow corners).
// Inputs change and outputs are checked on the falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mul_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [15:0] prod;
  logic        prod_valid;
  logic        acc_ready;

  logic        prod_ready24, acc_valid24, busy24, ovf24;
  logic [23:0] acc24;
  logic        prod_ready16, acc_valid16, busy16, ovf16;
  logic [15:0] acc16;

  int n_pass;
  int n_total;

  mul_accumulator #(.ACC_W(24)) u_dut24 (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready24), .acc(acc24),
    .acc_valid(acc_valid24), .acc_ready(acc_ready), .busy(busy24), .ovf(ovf24)
  );

  mul_accumulator #(.ACC_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready16), .acc(acc16),
    .acc_valid(acc_valid16), .acc_ready(acc_ready), .busy(busy16), .ovf(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; prod_valid = 1'b0; acc_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; len = 8'd3; prod = 16'h0001;
    prod_valid = 1'b1; acc_ready = 1'b1;
    step();
    n_total++;
    if ({busy24, prod_ready24, acc_valid24, ovf24} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {busy24, prod_ready24, acc_valid24, ovf24});
    else n_pass++;
    n_total++;
    if (acc24 !== 24'h000000) $display("FAIL reset_acc: got %h want 000000", acc24);
    else n_pass++;
    rst = 1'b0; start = 1'b0; prod_valid = 1'b0; acc_ready = 1'b0;
  endtask

  task automatic test_basic();
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0;
    n_total++;
    if ({busy24, prod_ready24, acc_valid24} !== 3'b110)
      $display("FAIL basic_acc_state: got %b want 110", {busy24, prod_ready24, acc_valid24});
    else n_pass++;
    prod_valid = 1'b1; prod = 16'h0003;
    step();
    prod = 16'hFFFE;
    step();
    prod = 16'h0010;
    n_total++;
    if (acc_valid24 !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", acc_valid24);
    else n_pass++;
    step();
    prod_valid = 1'b0;
    n_total++;
    if (acc_valid24 !== 1'b1 || acc24 !== 24'h000011 || ovf24 !== 1'b0)
      $display("FAIL basic_result: got valid=%b acc=%h ovf=%b want 1 000011 0",
               acc_valid24, acc24, ovf24);
    else n_pass++;
    n_total++;
    if (prod_ready24 !== 1'b0) $display("FAIL basic_hold_ready: got %b want 0", prod_ready24);
    else n_pass++;
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    n_total++;
    if (busy24 !== 1'b0 || acc_valid24 !== 1'b0 || acc24 !== 24'h000011)
      $display("FAIL basic_idle_keep: got busy=%b valid=%b acc=%h want 0 0 000011",
               busy24, acc_valid24, acc24);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic pv_seq [4];
    pv_seq[0] = 1'b1; pv_seq[1] = 1'b0; pv_seq[2] = 1'b0; pv_seq[3] = 1'b1;
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0;
    prod = 16'h0100;
    for (int i = 0; i < 4; i++) begin
      prod_valid = pv_seq[i];
      if (i == 3) prod = 16'h0200;
      step();
      if (i == 2) begin
        n_total++;
        if (acc24 !== 24'h000100 || acc_valid24 !== 1'b0)
          $display("FAIL bp_stall: got acc=%h valid=%b want 000100 0", acc24, acc_valid24);
        else n_pass++;
      end
    end
    // Products offered during HOLD must be refused
    prod_valid = 1'b1; prod = 16'h7777;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (acc_valid24 !== 1'b1 || acc24 !== 24'h000300 || prod_ready24 !== 1'b0)
        $display("FAIL bp_hold_%0d: got valid=%b acc=%h ready=%b want 1 000300 0",
                 i, acc_valid24, acc24, prod_ready24);
      else n_pass++;
      step();
    end
    prod_valid = 1'b0; acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    n_total++;
    if (busy24 !== 1'b0) $display("FAIL bp_release: got busy=%b want 0", busy24);
    else n_pass++;
  endtask

  task automatic run_pair(input logic [15:0] p);
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0; prod_valid = 1'b1; prod = p;
    step();
    step();
    prod_valid = 1'b0;
  endtask

  task automatic test_overflow();
    logic [15:0] exp_pos, exp_neg;
`ifdef MUL_ACCUMULATOR_SAT_EN
    exp_pos = 16'h7FFF; exp_neg = 16'h8000;
`else
    exp_pos = 16'hE000; exp_neg = 16'h0000;
`endif
    run_pair(16'h7000);
    n_total++;
    if (acc_valid16 !== 1'b1 || acc16 !== exp_pos || ovf16 !== 1'b1)
      $display("FAIL ovf_pos16: got valid=%b acc=%h ovf=%b want 1 %h 1",
               acc_valid16, acc16, ovf16, exp_pos);
    else n_pass++;
    n_total++;
    if (acc24 !== 24'h00E000 || ovf24 !== 1'b0)
      $display("FAIL ovf_none24: got acc=%h ovf=%b want 00E000 0", acc24, ovf24);
    else n_pass++;
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    n_total++;
    if (ovf16 !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf16);
    else n_pass++;
    run_pair(16'h8000);
    n_total++;
    if (acc16 !== exp_neg || ovf16 !== 1'b1)
      $display("FAIL ovf_neg16: got acc=%h ovf=%b want %h 1", acc16, ovf16, exp_neg);
    else n_pass++;
    n_total++;
    if (acc24 !== 24'hFF0000 || ovf24 !== 1'b0)
      $display("FAIL ovf_neg24: got acc=%h ovf=%b want FF0000 0", acc24, ovf24);
    else n_pass++;
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    // A new accepted start clears the sticky flag
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    n_total++;
    if (ovf16 !== 1'b0 || acc16 !== 16'h0000)
      $display("FAIL ovf_clear: got ovf=%b acc=%h want 0 0000", ovf16, acc16);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_len0();
    start = 1'b1; len = 8'd0;
    step();
    start = 1'b0; prod_valid = 1'b1; prod = 16'h0001;
    for (int i = 0; i < 255; i++) step();
    n_total++;
    if (acc_valid24 !== 1'b0 || acc24 !== 24'h0000FF)
      $display("FAIL len0_255: got valid=%b acc=%h want 0 0000FF", acc_valid24, acc24);
    else n_pass++;
    step();
    n_total++;
    if (acc_valid24 !== 1'b1 || acc24 !== 24'h000100 || acc16 !== 16'h0100)
      $display("FAIL len0_256: got valid=%b acc=%h acc16=%h want 1 000100 0100",
               acc_valid24, acc24, acc16);
    else n_pass++;
    step();
    step();
    n_total++;
    if (prod_ready24 !== 1'b0 || acc24 !== 24'h000100)
      $display("FAIL len0_257: got ready=%b acc=%h want 0 000100", prod_ready24, acc24);
    else n_pass++;
    prod_valid = 1'b0; acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic seen_valid;
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0; prod_valid = 1'b1; prod = 16'h0009;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++;
    if ({busy24, prod_ready24, acc_valid24, ovf24} !== 4'b0000 || acc24 !== 24'h000000)
      $display("FAIL rstmid_idle: got flags=%b acc=%h want 0000 000000",
               {busy24, prod_ready24, acc_valid24, ovf24}, acc24);
    else n_pass++;
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (acc_valid24 !== 1'b0 || acc24 !== 24'h000000) seen_valid = 1'b1;
    end
    n_total++;
    if (seen_valid !== 1'b0) $display("FAIL rstmid_quiet: got %b want 0", seen_valid);
    else n_pass++;
    prod_valid = 1'b0;
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0; prod_valid = 1'b1; prod = 16'h0005;
    step();
    prod_valid = 1'b0;
    n_total++;
    if (acc_valid24 !== 1'b1 || acc24 !== 24'h000005)
      $display("FAIL rstmid_new: got valid=%b acc=%h want 1 000005", acc_valid24, acc24);
    else n_pass++;
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
  endtask

  task automatic test_start_ignore();
    start = 1'b1; len = 8'd1;
    step();
    len = 8'd5;
    step();
    step();
    n_total++;
    if (busy24 !== 1'b1 || prod_ready24 !== 1'b1 || acc_valid24 !== 1'b0)
      $display("FAIL start_in_acc: got busy=%b ready=%b valid=%b want 1 1 0",
               busy24, prod_ready24, acc_valid24);
    else n_pass++;
    prod_valid = 1'b1; prod = 16'h0007;
    step();
    prod_valid = 1'b0;
    n_total++;
    if (acc_valid24 !== 1'b1 || acc24 !== 24'h000007)
      $display("FAIL start_len_kept: got valid=%b acc=%h want 1 000007", acc_valid24, acc24);
    else n_pass++;
    step();
    n_total++;
    if (acc_valid24 !== 1'b1 || busy24 !== 1'b1)
      $display("FAIL start_in_hold: got valid=%b busy=%b want 1 1", acc_valid24, busy24);
    else n_pass++;
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    n_total++;
    if (busy24 !== 1'b0 || acc24 !== 24'h000007)
      $display("FAIL start_handshake: got busy=%b acc=%h want 0 000007", busy24, acc24);
    else n_pass++;
    step();
    start = 1'b0;
    n_total++;
    if (busy24 !== 1'b1 || prod_ready24 !== 1'b1 || acc24 !== 24'h000000)
      $display("FAIL start_next_idle: got busy=%b ready=%b acc=%h want 1 1 000000",
               busy24, prod_ready24, acc24);
    else n_pass++;
    do_reset();
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; start = 1'b0; len = 8'd0; prod = 16'h0000;
    prod_valid = 1'b0; acc_ready = 1'b0;
    step();
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_len0();
    test_reset_mid();
    test_start_ignore();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
